// File: rtl/eth_tx_dma_timestamp_resp.sv
// TX egress timestamp response matcher.
// Pairs MAC timestamp responses with queued fingerprints and feeds the DMA.
module eth_tx_dma_timestamp_resp #(
  parameter int TS_WIDTH   = 96,
  parameter int FP_WIDTH   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 asi_fingerprint_valid,
  input  logic [FP_WIDTH-1:0]  asi_fingerprint,
  output logic                 asi_fingerprint_ready,
  input  logic                 tstamp_rsp_valid,
  input  logic [TS_WIDTH-1:0]  tstamp_rsp_data,
  input  logic [FP_WIDTH-1:0]  tstamp_rsp_fingerprint,
  output logic                 aso_ts_valid,
  input  logic                 aso_ts_ready,
  output logic [TS_WIDTH-1:0]  aso_ts_data,
  output logic [FP_WIDTH-1:0]  aso_ts_fingerprint,
  output logic [FIFO_AW:0]     pending_count,
  output logic [CNT_WIDTH-1:0] stat_matched,
  output logic [CNT_WIDTH-1:0] stat_skipped,
  output logic [CNT_WIDTH-1:0] stat_orphan,
  output logic [CNT_WIDTH-1:0] stat_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [FIFO_AW:0]     FULL     = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]     CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0]   PTR_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = 1;

  state_t state;
  state_t state_nxt;

  logic [FP_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count_nxt;
  logic                push;
  logic                pop;
  logic                empty;
  logic [FP_WIDTH-1:0] head;

  logic                hold_valid;
  logic [TS_WIDTH-1:0] hold_ts;
  logic [FP_WIDTH-1:0] hold_fp;
  logic                hold_clr;

  logic load_out;
  logic out_clr;
  logic inc_match;
  logic inc_skip;
  logic inc_orphan;
  logic inc_ovf;

  assign push    = asi_fingerprint_valid & asi_fingerprint_ready;
  assign empty   = (pending_count == '0);
  assign head    = mem[rd_ptr];
  assign inc_ovf = tstamp_rsp_valid & hold_valid;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = pending_count;
    if (push && !pop)
      count_nxt = pending_count + CNT_ONE;
    else if (!push && pop)
      count_nxt = pending_count - CNT_ONE;
  end

  // Fingerprint storage, no reset needed
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= asi_fingerprint;
  end

  // Queue pointers, occupancy and registered ready
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      pending_count         <= '0;
      asi_fingerprint_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      pending_count         <= count_nxt;
      asi_fingerprint_ready <= (count_nxt != FULL);
    end
  end

  // Single-entry hold register; a busy hold drops new responses
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_ts    <= '0;
      hold_fp    <= '0;
    end else if (tstamp_rsp_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_ts    <= tstamp_rsp_data;
      hold_fp    <= tstamp_rsp_fingerprint;
    end else if (hold_clr) begin
      hold_valid <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hold_valid)
          state_nxt = CHECK;
      end
      CHECK: begin
        if (empty)
          state_nxt = IDLE;
        else if (head == hold_fp)
          state_nxt = OUT;
      end
      OUT: begin
        if (aso_ts_valid && aso_ts_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    pop        = 1'b0;
    hold_clr   = 1'b0;
    load_out   = 1'b0;
    out_clr    = 1'b0;
    inc_match  = 1'b0;
    inc_skip   = 1'b0;
    inc_orphan = 1'b0;
    unique case (state)
      IDLE: ;
      CHECK: begin
        if (empty) begin
          inc_orphan = 1'b1;
          hold_clr   = 1'b1;
        end else if (head == hold_fp) begin
          pop       = 1'b1;
          load_out  = 1'b1;
          inc_match = 1'b1;
        end else begin
          pop      = 1'b1;
          inc_skip = 1'b1;
        end
      end
      OUT: begin
        if (aso_ts_valid && aso_ts_ready) begin
          out_clr  = 1'b1;
          hold_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered output toward the DMA
  always_ff @(posedge clock) begin
    if (reset) begin
      aso_ts_valid       <= 1'b0;
      aso_ts_data        <= '0;
      aso_ts_fingerprint <= '0;
    end else if (load_out) begin
      aso_ts_valid       <= 1'b1;
      aso_ts_data        <= hold_ts;
      aso_ts_fingerprint <= hold_fp;
    end else if (out_clr) begin
      aso_ts_valid <= 1'b0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_matched  <= '0;
      stat_skipped  <= '0;
      stat_orphan   <= '0;
      stat_overflow <= '0;
    end else begin
      if (inc_match && stat_matched != '1)
        stat_matched <= stat_matched + STAT_ONE;
      if (inc_skip && stat_skipped != '1)
        stat_skipped <= stat_skipped + STAT_ONE;
      if (inc_orphan && stat_orphan != '1)
        stat_orphan <= stat_orphan + STAT_ONE;
      if (inc_ovf && stat_overflow != '1)
        stat_overflow <= stat_overflow + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_eth_tx_dma_timestamp_resp.sv
// Testbench for eth_tx_dma_timestamp_resp.
// Vector table, corner sequences and randomized model comparison.
module tb_eth_tx_dma_timestamp_resp;

  localparam int TSW = 96;
  localparam int FPW = 8;
  localparam int AW  = 3;
  localparam int CW  = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           asi_fingerprint_valid = 1'b0;
  logic [FPW-1:0] asi_fingerprint = '0;
  logic           asi_fingerprint_ready;
  logic           tstamp_rsp_valid = 1'b0;
  logic [TSW-1:0] tstamp_rsp_data = '0;
  logic [FPW-1:0] tstamp_rsp_fingerprint = '0;
  logic           aso_ts_valid;
  logic           aso_ts_ready = 1'b0;
  logic [TSW-1:0] aso_ts_data;
  logic [FPW-1:0] aso_ts_fingerprint;
  logic [AW:0]    pending_count;
  logic [CW-1:0]  stat_matched;
  logic [CW-1:0]  stat_skipped;
  logic [CW-1:0]  stat_orphan;
  logic [CW-1:0]  stat_overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  eth_tx_dma_timestamp_resp dut (
    .clock                  (clock),
    .reset                  (reset),
    .asi_fingerprint_valid  (asi_fingerprint_valid),
    .asi_fingerprint        (asi_fingerprint),
    .asi_fingerprint_ready  (asi_fingerprint_ready),
    .tstamp_rsp_valid       (tstamp_rsp_valid),
    .tstamp_rsp_data        (tstamp_rsp_data),
    .tstamp_rsp_fingerprint (tstamp_rsp_fingerprint),
    .aso_ts_valid           (aso_ts_valid),
    .aso_ts_ready           (aso_ts_ready),
    .aso_ts_data            (aso_ts_data),
    .aso_ts_fingerprint     (aso_ts_fingerprint),
    .pending_count          (pending_count),
    .stat_matched           (stat_matched),
    .stat_skipped           (stat_skipped),
    .stat_orphan            (stat_orphan),
    .stat_overflow          (stat_overflow)
  );

  typedef struct {
    int             npush;
    logic [FPW-1:0] f0;
    logic [FPW-1:0] f1;
    logic [FPW-1:0] f2;
    logic [FPW-1:0] rfp;
    logic [TSW-1:0] ts;
    bit             match;
    int             lat;
    int             m;
    int             s;
    int             o;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_fp(input logic [FPW-1:0] fp);
    asi_fingerprint_valid = 1'b1;
    asi_fingerprint       = fp;
    tick();
    asi_fingerprint_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [FPW-1:0] fp,
                          input logic [TSW-1:0] ts);
    tstamp_rsp_valid       = 1'b1;
    tstamp_rsp_fingerprint = fp;
    tstamp_rsp_data        = ts;
    tick();
    tstamp_rsp_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < bound && !ok; c++) begin
      tick();
      cyc++;
      if (aso_ts_valid)
        ok = 1'b1;
    end
  endtask

  task automatic setv(input int idx, input int np,
                      input logic [FPW-1:0] a, input logic [FPW-1:0] b,
                      input logic [FPW-1:0] c, input logic [FPW-1:0] r,
                      input logic [TSW-1:0] ts, input bit mt,
                      input int lat, input int m, input int s,
                      input int o);
    vt[idx].npush = np;
    vt[idx].f0    = a;
    vt[idx].f1    = b;
    vt[idx].f2    = c;
    vt[idx].rfp   = r;
    vt[idx].ts    = ts;
    vt[idx].match = mt;
    vt[idx].lat   = lat;
    vt[idx].m     = m;
    vt[idx].s     = s;
    vt[idx].o     = o;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             cyc;
    bit             ok;
    int             bad;
    int             vcnt;
    logic [TSW-1:0] d0;
    logic [FPW-1:0] fp0;
    logic [FPW-1:0] pf;
    logic [FPW-1:0] mq[$];
    int             mm;
    int             ms;
    int             mo;
    logic [FPW-1:0] rfp;
    logic [TSW-1:0] rts;
    int             hit;
    int             np;

    setv(0, 1, 8'hA5, 8'h00, 8'h00, 8'hA5,
         96'h0000_0001_0000_0002_0003, 1, 2, 1, 0, 0);
    setv(1, 2, 8'hA5, 8'h4A, 8'h00, 8'h4A,
         96'h1234_5678_9ABC_DEF0_1122_3344, 1, 3, 2, 1, 0);
    setv(2, 0, 8'h00, 8'h00, 8'h00, 8'h33,
         96'h0000_0000_0000_0000_0000_0777, 0, 0, 2, 1, 1);
    setv(3, 3, 8'h11, 8'h22, 8'h33, 8'h44,
         96'h0000_0000_0000_0000_0000_0888, 0, 0, 2, 4, 2);
    setv(4, 3, 8'h01, 8'h02, 8'h03, 8'h03,
         96'hFFFF_0000_FFFF_0000_FFFF_0000, 1, 4, 3, 6, 2);

    // reset state
    tick();
    tick();
    chk("rst_ready", asi_fingerprint_ready, 1);
    chk("rst_valid", aso_ts_valid, 0);
    chk("rst_count", pending_count, 0);
    chk("rst_data", aso_ts_data, 0);
    chk("rst_matched", stat_matched, 0);
    reset = 1'b0;
    tick();

    // vector table
    aso_ts_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (vt[i].npush > 0) push_fp(vt[i].f0);
      if (vt[i].npush > 1) push_fp(vt[i].f1);
      if (vt[i].npush > 2) push_fp(vt[i].f2);
      chk($sformatf("v%0d_count_pre", i), pending_count, vt[i].npush);
      send_rsp(vt[i].rfp, vt[i].ts);
      if (vt[i].match) begin
        wait_valid(20, cyc, ok);
        chk($sformatf("v%0d_lat", i), ok ? cyc : -1, vt[i].lat);
        chk($sformatf("v%0d_fp", i), aso_ts_fingerprint, vt[i].rfp);
        chk($sformatf("v%0d_data", i), aso_ts_data, vt[i].ts);
        tick();
        chk($sformatf("v%0d_drop", i), aso_ts_valid, 0);
      end else begin
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
          tick();
          if (aso_ts_valid) vcnt++;
        end
        chk($sformatf("v%0d_novalid", i), vcnt, 0);
      end
      chk($sformatf("v%0d_count", i), pending_count, 0);
      chk($sformatf("v%0d_matched", i), stat_matched, vt[i].m);
      chk($sformatf("v%0d_skipped", i), stat_skipped, vt[i].s);
      chk($sformatf("v%0d_orphan", i), stat_orphan, vt[i].o);
    end

    // backpressure with a dropped second response
    aso_ts_ready = 1'b0;
    push_fp(8'h5A);
    send_rsp(8'h5A, 96'hABCD_EF01_2345_6789_0A0B_0C0D);
    wait_valid(20, cyc, ok);
    chk("bp_valid", ok, 1);
    d0  = aso_ts_data;
    fp0 = aso_ts_fingerprint;
    chk("bp_data", d0, 96'hABCD_EF01_2345_6789_0A0B_0C0D);
    bad = 0;
    send_rsp(8'h77, 96'h1);
    if (!(aso_ts_valid && aso_ts_data == d0 && aso_ts_fingerprint == fp0))
      bad++;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (!(aso_ts_valid && aso_ts_data == d0 && aso_ts_fingerprint == fp0))
        bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_overflow", stat_overflow, 1);
    aso_ts_ready = 1'b1;
    tick();
    chk("bp_accept", aso_ts_valid, 0);
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (aso_ts_valid) vcnt++;
    end
    chk("bp_single", vcnt, 0);
    chk("bp_matched", stat_matched, 4);
    chk("bp_orphan", stat_orphan, 2);

    // fill the queue and hold the ninth push off
    for (int i = 0; i < 8; i++)
      push_fp(8'(8'h10 + i));
    chk("full_ready", asi_fingerprint_ready, 0);
    chk("full_count", pending_count, 8);
    asi_fingerprint_valid = 1'b1;
    asi_fingerprint       = 8'h18;
    tick();
    tick();
    tick();
    chk("full_hold", pending_count, 8);
    send_rsp(8'h10, 96'h42);
    wait_valid(10, cyc, ok);
    chk("full_match", ok, 1);
    chk("full_pop_ready", asi_fingerprint_ready, 1);
    chk("full_pop_count", pending_count, 7);
    tick();
    asi_fingerprint_valid = 1'b0;
    chk("full_refill", pending_count, 8);
    chk("full_ready2", asi_fingerprint_ready, 0);

    // reset while holding an output
    aso_ts_ready = 1'b0;
    send_rsp(8'h11, 96'h99);
    wait_valid(10, cyc, ok);
    chk("mr_valid_pre", ok, 1);
    reset = 1'b1;
    tick();
    chk("mr_valid", aso_ts_valid, 0);
    chk("mr_data", aso_ts_data, 0);
    chk("mr_fp", aso_ts_fingerprint, 0);
    chk("mr_count", pending_count, 0);
    chk("mr_ready", asi_fingerprint_ready, 1);
    chk("mr_matched", stat_matched, 0);
    chk("mr_skipped", stat_skipped, 0);
    chk("mr_orphan", stat_orphan, 0);
    chk("mr_overflow", stat_overflow, 0);
    reset = 1'b0;
    tick();

    // randomized transactions against a queue model
    mm = 0;
    ms = 0;
    mo = 0;
    for (int t = 0; t < 40; t++) begin
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        if (mq.size() < 8) begin
          pf = 8'($urandom);
          chk("rnd_push_ready", asi_fingerprint_ready, 1);
          push_fp(pf);
          mq.push_back(pf);
        end
      end
      if (mq.size() > 0 && $urandom_range(0, 9) < 7)
        rfp = mq[$urandom_range(0, mq.size() - 1)];
      else
        rfp = 8'($urandom);
      rts = {$urandom, $urandom, $urandom};
      hit = -1;
      for (int j = 0; j < mq.size() && hit < 0; j++)
        if (mq[j] == rfp) hit = j;
      if (hit >= 0) begin
        ms += hit;
        mm++;
        for (int j = 0; j <= hit; j++) void'(mq.pop_front());
      end else begin
        ms += mq.size();
        mo++;
        mq.delete();
      end
      send_rsp(rfp, rts);
      if (hit >= 0) begin
        ok  = 1'b0;
        bad = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
          tick();
          if (aso_ts_valid) begin
            if (bad == 0) begin
              chk("rnd_fp", aso_ts_fingerprint, rfp);
              chk("rnd_data", aso_ts_data, rts);
              bad = 1;
            end
            aso_ts_ready = 1'($urandom_range(0, 1));
            if (aso_ts_ready) begin
              tick();
              ok = 1'b1;
            end
          end
        end
        aso_ts_ready = 1'b0;
        chk("rnd_xfer", ok, 1);
        chk("rnd_drop", aso_ts_valid, 0);
      end else begin
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
          tick();
          if (aso_ts_valid) vcnt++;
        end
        chk("rnd_novalid", vcnt, 0);
      end
      chk("rnd_count", pending_count, mq.size());
      chk("rnd_matched", stat_matched, mm);
      chk("rnd_skipped", stat_skipped, ms);
      chk("rnd_orphan", stat_orphan, mo);
      chk("rnd_overflow", stat_overflow, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_dma_timestamp_resp.md
Name: eth_tx_dma_timestamp_resp

Overview:
Receives TX egress timestamp responses from the Ethernet MAC and pairs each one with a fingerprint issued earlier by the TX timestamp request block. Fingerprints of transmitted packets arrive in order on an AVST sink and are queued as pending. Each MAC response is checked against the head of that queue. Matched timestamps go to the DMA on an AVST source; lost and orphan events are counted.

Parameters:
TS_WIDTH, 96, MAC timestamp width (48b seconds + 32b ns + 16b fractional ns)
FP_WIDTH, 8, fingerprint width
FIFO_DEPTH, 8, pending-fingerprint queue depth (power of 2)
FIFO_AW, 3, log2(FIFO_DEPTH)
CNT_WIDTH, 16, statistics counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
asi_fingerprint_valid  in  1  pending fingerprint valid
asi_fingerprint  in  FP_WIDTH  fingerprint of a transmitted packet
asi_fingerprint_ready  out  1  queue can accept
tstamp_rsp_valid  in  1  MAC response strobe, single cycle, no backpressure
tstamp_rsp_data  in  TS_WIDTH  egress timestamp
tstamp_rsp_fingerprint  in  FP_WIDTH  fingerprint echoed by MAC
aso_ts_valid  out  1  matched timestamp valid
aso_ts_ready  in  1  DMA accepts
aso_ts_data  out  TS_WIDTH  matched timestamp
aso_ts_fingerprint  out  FP_WIDTH  matched fingerprint
pending_count  out  FIFO_AW+1  queue occupancy
stat_matched  out  CNT_WIDTH  responses matched
stat_skipped  out  CNT_WIDTH  pending fingerprints discarded without response
stat_orphan  out  CNT_WIDTH  responses with no pending fingerprint
stat_overflow  out  CNT_WIDTH  responses dropped because hold register busy

Behaviour:
- Reset (synchronous, active-high; clock clock): queue emptied, hold register cleared, FSM=IDLE. All outputs 0 except asi_fingerprint_ready=1.
- Reset mid-operation discards the in-flight response and any un-accepted output. aso_ts_valid drops the cycle after reset is sampled.
- Queue: FIFO, asi_fingerprint_ready = !full, registered from occupancy. Push on valid&ready. A pop in the same cycle does not raise ready while full.
- pending_count updates the cycle after push/pop. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Hold register: 1 entry (ts, fp, hold_valid).
  - tstamp_rsp_valid with hold_valid=0: capture, set hold_valid.
  - tstamp_rsp_valid with hold_valid=1: drop the response, stat_overflow++. This applies even in the cycle the hold is being released.
- FSM states:
  - IDLE: hold_valid=1 -> CHECK.
  - CHECK, queue empty: stat_orphan++, clear hold -> IDLE.
  - CHECK, head==hold fp: pop, load aso_ts_data/aso_ts_fingerprint, set aso_ts_valid, stat_matched++ -> OUT.
  - CHECK, head!=hold fp: pop, stat_skipped++, stay CHECK and compare the new head next cycle.
  - OUT: hold aso_ts_valid and data stable until aso_ts_ready. On valid&ready: clear aso_ts_valid and hold -> IDLE.
- Latency: response sampled at edge k -> hold_valid in cycle k+1 (IDLE) -> CHECK in k+2 -> aso_ts_valid in k+3 on a head match. Each skip adds 1 cycle.
- aso_ts_valid never depends combinationally on aso_ts_ready. Data is registered.
- All stat counters saturate at 2^CNT_WIDTH-1 and never wrap.
- The queue accepts pushes in every FSM state.

Test Plan:
1. Push fingerprint 0xA5, then response fp=0xA5, ts=0x0000_0001_0000_0002_0003 with aso_ts_ready=1 -> aso_ts_valid 3 cycles after the strobe, data/fp match, stat_matched=1, pending_count 1->0.
2. Push 0xA5, 0x4A; response fp=0x4A -> 0xA5 skipped (stat_skipped=1), output fp=0x4A, stat_matched=1, pending_count=0.
3. Queue empty; response fp=0x33 -> no output, stat_orphan=1, FSM back to IDLE, hold cleared.
4. aso_ts_ready=0 for 10 cycles after a match while a second response arrives -> output stable throughout, second response dropped, stat_overflow=1. After ready, one transfer only.
5. Push 9 fingerprints back-to-back -> ready deasserts after the 8th, pending_count=8, 9th held by source. One match-pop -> ready reasserts the next cycle, count returns to 8 after the push.
6. Assert reset while in OUT with aso_ts_valid=1 -> next cycle all outputs 0, pending_count=0, counters 0, ready=1.
